// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one memory request in flight, and registers the word plus its PC toward decode.
// A response shows up on F_valid one cycle after F_mem_rvalid; decode stalls go to a 1-entry skid, and issue stops while the skid is full.
module fetch_stage #(
  parameter int unsigned             ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0,
  parameter logic [ADDRESS_SIZE-1:0] NOP_INSTR    = ADDRESS_SIZE'(32'h0000_0013)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    F_mem_req,
  output logic [ADDRESS_SIZE-1:0] F_mem_addr,
  input  logic                    F_mem_ready,
  input  logic                    F_mem_rvalid,
  input  logic [ADDRESS_SIZE-1:0] F_mem_rdata,
  input  logic                    F_stall,
  input  logic                    F_redirect,
  input  logic [ADDRESS_SIZE-1:0] F_redirect_pc,
  output logic                    F_valid,
  output logic [ADDRESS_SIZE-1:0] F_instruction,
  output logic [ADDRESS_SIZE-1:0] F_pc
);

  logic [ADDRESS_SIZE-1:0] r_pc;
  logic [ADDRESS_SIZE-1:0] r_req_pc;
  logic                    r_outstanding;
  logic                    r_kill;
  logic                    r_out_vld;
  logic [ADDRESS_SIZE-1:0] r_out_instr;
  logic [ADDRESS_SIZE-1:0] r_out_pc;
  logic                    r_skid_vld;
  logic [ADDRESS_SIZE-1:0] r_skid_instr;
  logic [ADDRESS_SIZE-1:0] r_skid_pc;

  logic w_consume;
  logic w_resp;
  logic w_take;
  logic w_accept;

  assign w_consume = r_out_vld && !F_stall;
  assign w_resp    = F_mem_rvalid && r_outstanding;
  assign w_take    = w_resp && !r_kill;
  // rst_n gates the request so the interface stays quiet while held in reset
  assign F_mem_req = rst_n && !r_outstanding && !r_skid_vld && !F_redirect;
  assign w_accept  = F_mem_req && F_mem_ready;

  assign F_mem_addr    = r_pc;
  assign F_valid       = r_out_vld;
  assign F_instruction = r_out_instr;
  assign F_pc          = r_out_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_outstanding <= 1'b0;
      r_kill        <= 1'b0;
      r_out_vld     <= 1'b0;
      r_out_instr   <= NOP_INSTR;
      r_out_pc      <= '0;
      r_skid_vld    <= 1'b0;
      r_skid_instr  <= NOP_INSTR;
      r_skid_pc     <= '0;
    end else if (F_redirect) begin
      // A response landing with the redirect is dropped here; otherwise the in-flight one is marked for discard
      r_pc          <= F_redirect_pc & ~ADDRESS_SIZE'(3);
      r_outstanding <= r_outstanding && !F_mem_rvalid;
      r_kill        <= r_outstanding && !F_mem_rvalid;
      r_out_vld     <= 1'b0;
      r_out_instr   <= NOP_INSTR;
      r_skid_vld    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req_pc      <= r_pc;
        r_pc          <= r_pc + ADDRESS_SIZE'(4);
        r_outstanding <= 1'b1;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
        r_kill        <= 1'b0;
      end

      if (w_consume && r_skid_vld) begin
        r_out_instr  <= r_skid_instr;
        r_out_pc     <= r_skid_pc;
        r_skid_vld   <= w_take;
        r_skid_instr <= F_mem_rdata;
        r_skid_pc    <= r_req_pc;
      end else if (w_take && (!r_out_vld || w_consume)) begin
        r_out_vld   <= 1'b1;
        r_out_instr <= F_mem_rdata;
        r_out_pc    <= r_req_pc;
      end else if (w_take) begin
        r_skid_vld   <= 1'b1;
        r_skid_instr <= F_mem_rdata;
        r_skid_pc    <= r_req_pc;
      end else if (w_consume) begin
        r_out_vld   <= 1'b0;
        r_out_instr <= NOP_INSTR;
      end
    end
  end

endmodule
